sram_ctrl: RTL and testbench

- Sits directly downstream of the acquisition block and owns the external asynchronous SRAM.
- Accepts the acquisition sample write stream (addr/data/wen, one word per clk, no backpressure) and commits it to SRAM.
- Services host readout requests through a req/valid handshake.
- Writes always win; a read in flight is aborted and replayed after the write burst ends.

---
 rtl/sram_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_sram_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// sram_ctrl: commits the acquisition write stream to an asynchronous SRAM and serves host reads.
// Writes always preempt reads. Define SRAM_CTRL_WR_CNT_EN to add the committed-write counter.
module sram_ctrl #(
   parameter int RAM_DATA_W     = 16,
   parameter int RAM_ADDR_W     = 19,
   parameter int RD_WAIT_CYCLES = 2,
   parameter int TURN_CYCLES    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [RAM_ADDR_W-1:0] wr_addr,
   input  logic [RAM_DATA_W-1:0] wr_data,
   input  logic                  rd_req,
   input  logic [RAM_ADDR_W-1:0] rd_addr,
   output logic                  rd_valid,
   output logic [RAM_DATA_W-1:0] rd_data,
   output logic                  rd_busy,
   output logic [RAM_ADDR_W-1:0] ram_addr,
   output logic [RAM_DATA_W-1:0] ram_data_o,
   input  logic [RAM_DATA_W-1:0] ram_data_i,
   output logic                  ram_data_oe,
   output logic                  ram_we_n,
   output logic                  ram_oe_n,
   output logic                  ram_ce_n
`ifdef SRAM_CTRL_WR_CNT_EN
   ,
   input  logic                  wr_cnt_clr,
   output logic [RAM_ADDR_W:0]   wr_cnt
`endif
);
   localparam int WAIT_W = $clog2(RD_WAIT_CYCLES + 1);
   localparam int TURN_W = $clog2(TURN_CYCLES + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_WAIT_CYCLES - 2);
   localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_TURN     = 3'd1,
      ST_RD_SETUP = 3'd2,
      ST_RD_WAIT  = 3'd3,
      ST_RD_DONE  = 3'd4
   } state_t;

   state_t                state_r, state_s;
   logic [WAIT_W-1:0]     wait_cnt_r, wait_cnt_s;
   logic [TURN_W-1:0]     turn_cnt_r, turn_cnt_s;
   logic                  accept_s, rd_path_s;
   logic [RAM_ADDR_W-1:0] ram_addr_r, ram_addr_s;
   logic [RAM_DATA_W-1:0] ram_data_o_r, ram_data_o_s;
   logic                  ram_data_oe_r, ram_data_oe_s;
   logic                  ram_we_n_r, ram_we_n_s;
   logic                  ram_oe_n_r, ram_oe_n_s;
   logic                  ram_ce_n_r, ram_ce_n_s;
   logic                  rd_valid_r, rd_valid_s;
   logic [RAM_DATA_W-1:0] rd_data_r, rd_data_s;
   logic                  rd_busy_r, rd_busy_s;

   // Next-state, counters and next values of every registered output.
   always_comb begin
      state_s    = state_r;
      wait_cnt_s = wait_cnt_r;
      turn_cnt_s = turn_cnt_r;
      accept_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (rd_req) begin
               accept_s = 1'b1;
               if (wr_en || !ram_we_n_r) begin
                  state_s    = ST_TURN;
                  turn_cnt_s = '0;
               end else begin
                  state_s = ST_RD_SETUP;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_TURN: begin
            // a cycle only counts as idle once the bus has stopped writing
            if (wr_en || !ram_we_n_r) begin
               turn_cnt_s = '0;
            end else if (turn_cnt_r == TURN_LAST) begin
               state_s    = ST_RD_SETUP;
               turn_cnt_s = '0;
            end else begin
               turn_cnt_s = turn_cnt_r + TURN_W'(1);
            end
         end
         ST_RD_SETUP: begin
            if (wr_en) begin
               state_s    = ST_TURN;
               turn_cnt_s = '0;
            end else if (RD_WAIT_CYCLES == 1) begin
               state_s = ST_RD_DONE;
            end else begin
               state_s    = ST_RD_WAIT;
               wait_cnt_s = '0;
            end
         end
         ST_RD_WAIT: begin
            if (wr_en) begin
               state_s    = ST_TURN;
               turn_cnt_s = '0;
            end else if (wait_cnt_r == WAIT_LAST) begin
               state_s = ST_RD_DONE;
            end else begin
               wait_cnt_s = wait_cnt_r + WAIT_W'(1);
            end
         end
         ST_RD_DONE: begin
            if (wr_en) begin
               state_s    = ST_TURN;
               turn_cnt_s = '0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      rd_path_s = (state_s == ST_RD_SETUP) || (state_s == ST_RD_WAIT) || (state_s == ST_RD_DONE);
      ram_addr_s   = ram_addr_r;
      ram_data_o_s = ram_data_o_r;
      if (wr_en) begin
         ram_addr_s    = wr_addr;
         ram_data_o_s  = wr_data;
         ram_data_oe_s = 1'b1;
         ram_we_n_s    = 1'b0;
         ram_oe_n_s    = 1'b1;
         ram_ce_n_s    = 1'b0;
      end else if (rd_path_s) begin
         ram_addr_s    = rd_addr;
         ram_data_oe_s = 1'b0;
         ram_we_n_s    = 1'b1;
         ram_oe_n_s    = 1'b0;
         ram_ce_n_s    = 1'b0;
      end else begin
         ram_data_oe_s = 1'b0;
         ram_we_n_s    = 1'b1;
         ram_oe_n_s    = 1'b1;
         ram_ce_n_s    = 1'b1;
      end

      if ((state_r == ST_RD_DONE) && !wr_en) begin
         rd_valid_s = 1'b1;
         rd_data_s  = ram_data_i;
      end else begin
         rd_valid_s = 1'b0;
         rd_data_s  = rd_data_r;
      end

      // busy covers the rd_valid cycle and drops on the following edge
      if (accept_s) begin
         rd_busy_s = 1'b1;
      end else if (rd_valid_r) begin
         rd_busy_s = 1'b0;
      end else begin
         rd_busy_s = rd_busy_r;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         wait_cnt_r    <= '0;
         turn_cnt_r    <= '0;
         ram_addr_r    <= '0;
         ram_data_o_r  <= '0;
         ram_data_oe_r <= 1'b0;
         ram_we_n_r    <= 1'b1;
         ram_oe_n_r    <= 1'b1;
         ram_ce_n_r    <= 1'b1;
         rd_valid_r    <= 1'b0;
         rd_data_r     <= '0;
         rd_busy_r     <= 1'b0;
      end else begin
         state_r       <= state_s;
         wait_cnt_r    <= wait_cnt_s;
         turn_cnt_r    <= turn_cnt_s;
         ram_addr_r    <= ram_addr_s;
         ram_data_o_r  <= ram_data_o_s;
         ram_data_oe_r <= ram_data_oe_s;
         ram_we_n_r    <= ram_we_n_s;
         ram_oe_n_r    <= ram_oe_n_s;
         ram_ce_n_r    <= ram_ce_n_s;
         rd_valid_r    <= rd_valid_s;
         rd_data_r     <= rd_data_s;
         rd_busy_r     <= rd_busy_s;
      end
   end

   assign ram_addr    = ram_addr_r;
   assign ram_data_o  = ram_data_o_r;
   assign ram_data_oe = ram_data_oe_r;
   assign ram_we_n    = ram_we_n_r;
   assign ram_oe_n    = ram_oe_n_r;
   assign ram_ce_n    = ram_ce_n_r;
   assign rd_valid    = rd_valid_r;
   assign rd_data     = rd_data_r;
   assign rd_busy     = rd_busy_r;

`ifdef SRAM_CTRL_WR_CNT_EN
   localparam int CNT_W = RAM_ADDR_W + 1;
   logic [CNT_W-1:0] wr_cnt_r;

   // Saturating count of cycles the SRAM is being written; clear wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_cnt_r <= '0;
      end else if (wr_cnt_clr) begin
         wr_cnt_r <= '0;
      end else if (!ram_we_n_r && !(&wr_cnt_r)) begin
         wr_cnt_r <= wr_cnt_r + CNT_W'(1);
      end else begin
         wr_cnt_r <= wr_cnt_r;
      end
   end

   assign wr_cnt = wr_cnt_r;
`endif
endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: vector table, directed multi-cycle sequences and a
// randomized run scored against a behavioural SRAM content model.
module tb_sram_ctrl;
   localparam int AW = 19;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          rd_req = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic          rd_valid, rd_busy, ram_data_oe, ram_we_n, ram_oe_n, ram_ce_n;
   logic [DW-1:0] rd_data, ram_data_o, ram_data_i;
   logic [AW-1:0] ram_addr;
`ifdef SRAM_CTRL_WR_CNT_EN
   logic          wr_cnt_clr = 1'b0;
   logic [AW:0]   wr_cnt;
`endif

   sram_ctrl dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
      .rd_busy(rd_busy), .ram_addr(ram_addr), .ram_data_o(ram_data_o),
      .ram_data_i(ram_data_i), .ram_data_oe(ram_data_oe), .ram_we_n(ram_we_n),
      .ram_oe_n(ram_oe_n), .ram_ce_n(ram_ce_n)
`ifdef SRAM_CTRL_WR_CNT_EN
      , .wr_cnt_clr(wr_cnt_clr), .wr_cnt(wr_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Model of the external asynchronous SRAM.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   assign ram_data_i = (!ram_oe_n && !ram_ce_n && !ram_data_oe) ? mem[ram_addr] : '0;
   always @(posedge clk) if (!ram_we_n && !ram_ce_n) mem[ram_addr] <= ram_data_o;

   int total = 0;
   int bad = 0;
   int we_low_cnt = 0, oe_low_cnt = 0, valid_cnt = 0;
   logic [DW-1:0] ref_mem [int];

   typedef struct {
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          x_we_n;
      logic          x_data_oe;
      logic          x_ce_n;
      logic          chk_ad;
   } vec_t;
   vec_t vt [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      if (wr_en) ref_mem[int'(wr_addr)] = wr_data;
      @(posedge clk);
      #1;
      if (!ram_we_n) we_low_cnt++;
      if (!ram_oe_n) oe_low_cnt++;
      if (rd_valid) valid_cnt++;
      if (!ram_oe_n && !ram_we_n) chk("bus_conflict", 32'd1, 32'd0);
   endtask

   task automatic chk_reset(input string p);
      chk({p, "_we_n"}, ram_we_n, 1);
      chk({p, "_oe_n"}, ram_oe_n, 1);
      chk({p, "_ce_n"}, ram_ce_n, 1);
      chk({p, "_data_oe"}, ram_data_oe, 0);
      chk({p, "_addr"}, ram_addr, 0);
      chk({p, "_data_o"}, ram_data_o, 0);
      chk({p, "_rd_valid"}, rd_valid, 0);
      chk({p, "_rd_data"}, rd_data, 0);
      chk({p, "_rd_busy"}, rd_busy, 0);
   endtask

   task automatic wr_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   // Waits (bounded) for rd_valid; lat counts edges from the rd_req edge.
   task automatic wait_valid(inout int lat, output logic ok);
      while (!rd_valid && lat < 60) begin
         step();
         lat++;
      end
      ok = rd_valid;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, errs, pend, wait_cyc, reads;
      logic ok, p_we;
      logic [AW-1:0] p_a;
      logic [DW-1:0] p_d;

      vt[0] = '{1'b1, 19'h00010, 16'h01A5, 1'b0, 1'b1, 1'b0, 1'b1};
      vt[1] = '{1'b0, 19'h00000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
      vt[2] = '{1'b1, 19'h00011, 16'h0222, 1'b0, 1'b1, 1'b0, 1'b1};
      vt[3] = '{1'b1, 19'h00012, 16'h0333, 1'b0, 1'b1, 1'b0, 1'b1};
      vt[4] = '{1'b1, 19'h7FFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1};
      vt[5] = '{1'b0, 19'h00000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};

      // reset state
      repeat (2) @(negedge clk);
      chk_reset("rst_init");
      @(negedge clk);
      rst = 1'b0;

      // write path vectors
      for (int i = 0; i < 6; i++) begin
         wr_en = vt[i].we; wr_addr = vt[i].a; wr_data = vt[i].d;
         step();
         chk($sformatf("vec%0d_we_n", i), ram_we_n, vt[i].x_we_n);
         chk($sformatf("vec%0d_data_oe", i), ram_data_oe, vt[i].x_data_oe);
         chk($sformatf("vec%0d_ce_n", i), ram_ce_n, vt[i].x_ce_n);
         chk($sformatf("vec%0d_oe_n", i), ram_oe_n, 1);
         if (vt[i].chk_ad) begin
            chk($sformatf("vec%0d_addr", i), ram_addr, vt[i].a);
            chk($sformatf("vec%0d_data_o", i), ram_data_o, vt[i].d);
         end
      end
      wr_en = 1'b0;

      // 16384-word burst
      we_low_cnt = 0;
      for (int i = 0; i < 16384; i++) begin
         wr_en = 1'b1; wr_addr = AW'(i); wr_data = DW'(i) ^ 16'h5A5A;
         step();
         chk("burst_addr", ram_addr, i);
         chk("burst_we_n", ram_we_n, 0);
      end
      wr_en = 1'b0;
      step();
      chk("burst_end_we_n", ram_we_n, 1);
      chk("burst_end_data_oe", ram_data_oe, 0);
      chk("burst_we_low_cycles", we_low_cnt, 16384);
      errs = 0;
      for (int i = 0; i < 16384; i++) if (mem[i] !== (DW'(i) ^ 16'h5A5A)) errs++;
      chk("burst_mem_errors", errs, 0);

      // plain read
      wr_word(19'h00020, 16'hBEEF);
      repeat (3) step();
      rd_req = 1'b1; rd_addr = 19'h00020;
      oe_low_cnt = 0;
      step();
      rd_req = 1'b0;
      chk("rd_busy_accept", rd_busy, 1);
      lat = 1;
      wait_valid(lat, ok);
      chk("rd_valid_seen", ok, 1);
      chk("rd_latency", lat, 4);
      chk("rd_data", rd_data, 16'hBEEF);
      chk("rd_oe_low_cycles", oe_low_cnt, 3);
      chk("rd_oe_n_after", ram_oe_n, 1);
      step();
      chk("rd_valid_pulse", rd_valid, 0);
      chk("rd_busy_done", rd_busy, 0);
      chk("rd_data_held", rd_data, 16'hBEEF);

      // write preempts a read in RD_WAIT, then replay
      wr_word(19'h00030, 16'h1234);
      repeat (3) step();
      valid_cnt = 0;
      rd_req = 1'b1; rd_addr = 19'h00030;
      step();
      rd_req = 1'b0;
      step();
      chk("pre_wait_oe_n", ram_oe_n, 0);
      wr_word(19'h00040, 16'h7777);
      chk("pre_wr_oe_n", ram_oe_n, 1);
      chk("pre_wr_we_n", ram_we_n, 0);
      chk("pre_wr_addr", ram_addr, 19'h00040);
      chk("pre_no_valid", rd_valid, 0);
      step();
      chk("pre_turn_oe_n", ram_oe_n, 1);
      chk("pre_turn_we_n", ram_we_n, 1);
      chk("pre_turn_busy", rd_busy, 1);
      step();
      chk("pre_replay_oe_n", ram_oe_n, 0);
      chk("pre_replay_addr", ram_addr, 19'h00030);
      lat = 0;
      wait_valid(lat, ok);
      chk("pre_valid_seen", ok, 1);
      chk("pre_replay_lat", lat, 3);
      chk("pre_rd_data", rd_data, 16'h1234);
      chk("pre_valid_count", valid_cnt, 1);
      chk("pre_mem_40", mem[19'h00040], 16'h7777);

      // reset during RD_WAIT
      step();
      rd_req = 1'b1; rd_addr = 19'h00020;
      step();
      rd_req = 1'b0;
      step();
      #2 rst = 1'b1;
      #1 chk_reset("rst_mid");
      @(negedge clk);
      rst = 1'b0;
      valid_cnt = 0;
      repeat (10) step();
      chk("rst_mid_no_valid", valid_cnt, 0);

      // randomized traffic against the content model
      pend = 0; wait_cyc = 0; reads = 0;
      for (int c = 0; c < 1500; c++) begin
         wr_en = ($urandom_range(0, 3) == 0);
         wr_addr = AW'($urandom_range(0, 31));
         wr_data = DW'($urandom);
         if (pend == 0 && !rd_busy && $urandom_range(0, 3) == 0) begin
            rd_req = 1'b1; rd_addr = AW'($urandom_range(0, 31));
            pend = 1; wait_cyc = 0; reads++;
         end else begin
            rd_req = 1'b0;
         end
         p_we = wr_en; p_a = wr_addr; p_d = wr_data;
         step();
         chk("rnd_we_n", ram_we_n, !p_we);
         if (p_we) begin
            chk("rnd_addr", ram_addr, p_a);
            chk("rnd_data_o", ram_data_o, p_d);
         end
         if (rd_valid) begin
            chk("rnd_valid_pending", pend, 1);
            chk("rnd_rd_data", rd_data, ref_mem[int'(rd_addr)]);
            pend = 0;
         end else if (pend != 0) begin
            wait_cyc++;
            if (wait_cyc == 300) chk("rnd_read_timeout", wait_cyc, 0);
         end
      end
      wr_en = 1'b0; rd_req = 1'b0;
      for (int k = 0; k < 30 && pend != 0; k++) begin
         step();
         if (rd_valid) begin
            chk("rnd_drain_rd_data", rd_data, ref_mem[int'(rd_addr)]);
            pend = 0;
         end
      end
      chk("rnd_all_reads_done", pend, 0);
      chk("rnd_reads_issued", (reads > 20), 1);

`ifdef SRAM_CTRL_WR_CNT_EN
      repeat (2) step();
      wr_cnt_clr = 1'b1;
      step();
      wr_cnt_clr = 1'b0;
      chk("cnt_cleared", wr_cnt, 0);
      for (int i = 0; i < 100; i++) wr_word(AW'(i), DW'(i));
      repeat (2) step();
      chk("cnt_100", wr_cnt, 100);
      wr_word(19'h00001, 16'h0001);
      wr_cnt_clr = 1'b1;
      step();
      wr_cnt_clr = 1'b0;
      chk("cnt_clr_priority", wr_cnt, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
